// File: rtl/fft_round_sat_pipe_pkg.sv
// Shared types and the rounding-bias helper for the FFT requantiser.
package fft_round_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_ZERO = 2'd1,
        RND_HALF_AWAY = 2'd2,
        RND_HALF_EVEN = 2'd3
    } rnd_mode_e;

    // Value added before the floor shift so that the shift lands on the chosen rounding.
    function automatic int unsigned bias(input logic x_sign, input logic keep_lsb,
                                         input rnd_mode_e mode, input int unsigned shift);
        int unsigned h;
        h    = 32'd1 << (shift - 32'd1);
        bias = 32'd0;
        case (mode)
            RND_TRUNC:     bias = 32'd0;
            RND_HALF_ZERO: bias = x_sign ? h : h - 32'd1;
            RND_HALF_AWAY: bias = x_sign ? h - 32'd1 : h;
            RND_HALF_EVEN: bias = h - 32'd1 + 32'(keep_lsb);
            default:       bias = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/fft_round_sat_pipe_if.sv
// Complex-sample stream: input beat side and output beat side of the requantiser.
interface fft_round_sat_pipe_if
    import fft_round_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_re;
    logic [IN_W-1:0]  in_im;
    logic             in_last;
    rnd_mode_e        in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_re;
    logic [OUT_W-1:0] out_im;
    logic             out_last;
    logic             out_sat;

    modport master (
        output in_valid, in_re, in_im, in_last, in_mode, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last, out_sat
    );

    modport slave (
        input  in_valid, in_re, in_im, in_last, in_mode, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last, out_sat
    );
endinterface

// File: rtl/fft_round_sat_pipe_lane.sv
// One component lane: S1 rounds and drops SHIFT LSBs, S2 saturates to OUT_W bits.
module fft_round_sat_lane
    import fft_round_pkg::*;
#(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 12,
    parameter int unsigned SHIFT   = 4,
    parameter bit          SYM_SAT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic [IN_W-1:0]  x,
    input  rnd_mode_e        mode,
    output logic [OUT_W-1:0] y,
    output logic             sat_c
);
    localparam int unsigned EXT_W = IN_W + 1;
    localparam int unsigned R_W   = EXT_W - SHIFT;
    localparam int          MAX_I = (2 ** (OUT_W - 1)) - 1;
    localparam int          MIN_I = SYM_SAT ? -MAX_I : -MAX_I - 1;
    localparam logic signed [R_W-1:0] MAX_R = R_W'(MAX_I);
    localparam logic signed [R_W-1:0] MIN_R = R_W'(MIN_I);

    logic signed [EXT_W-1:0] sum_c;
    logic signed [R_W-1:0]   r_c;
    logic signed [R_W-1:0]   r_q;
    logic                    hi_c;
    logic                    lo_c;

    // One extra bit of headroom keeps x + bias from wrapping before the floor shift.
    always_comb begin
        sum_c = $signed({x[IN_W-1], x})
              + $signed(EXT_W'(bias(x[IN_W-1], x[SHIFT], mode, SHIFT)));
        r_c   = R_W'(sum_c >>> SHIFT);
    end

    always_comb begin
        hi_c  = r_q > MAX_R;
        lo_c  = r_q < MIN_R;
        sat_c = hi_c | lo_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            y   <= '0;
        end else begin
            if (s1_en) r_q <= r_c;
            if (s2_en) begin
                if (hi_c)      y <= OUT_W'(MAX_I);
                else if (lo_c) y <= OUT_W'(MIN_I);
                else           y <= OUT_W'(r_q);
            end
        end
    end

endmodule

// File: rtl/fft_round_sat_pipe.sv
// Two-stage complex requantiser with valid/ready flow control and saturation statistics.
module fft_round_sat_pipe
    import fft_round_pkg::*;
#(
    parameter int unsigned IN_W    = 16,
    parameter int unsigned OUT_W   = 12,
    parameter int unsigned SHIFT   = 4,
    parameter bit          SYM_SAT = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_round_sat_pipe_if.slave bus,
    input  logic               stat_clr,
    output logic [CNT_W-1:0]   sat_count,
    output logic               sat_sticky
);
    logic s1_valid;
    logic s1_last;
    logic s1_load_c;
    logic s2_load_c;
    logic s1_en_c;
    logic s2_en_c;
    logic sat_re_c;
    logic sat_im_c;
    logic sat_hit_c;

    // Each stage advances when it is empty or the stage after it is advancing.
    assign s2_load_c    = !bus.out_valid | bus.out_ready;
    assign s1_load_c    = !s1_valid | s2_load_c;
    assign s1_en_c      = s1_load_c & bus.in_valid;
    assign s2_en_c      = s2_load_c & s1_valid;
    assign bus.in_ready = s1_load_c;
    assign sat_hit_c    = bus.out_valid & bus.out_ready & bus.out_sat;

    fft_round_sat_lane #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .SYM_SAT(SYM_SAT)
    ) u_lane_re (
        .clk(clk), .rst_n(rst_n), .s1_en(s1_en_c), .s2_en(s2_en_c),
        .x(bus.in_re), .mode(bus.in_mode), .y(bus.out_re), .sat_c(sat_re_c)
    );

    fft_round_sat_lane #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .SYM_SAT(SYM_SAT)
    ) u_lane_im (
        .clk(clk), .rst_n(rst_n), .s1_en(s1_en_c), .s2_en(s2_en_c),
        .x(bus.in_im), .mode(bus.in_mode), .y(bus.out_im), .sat_c(sat_im_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_sat   <= 1'b0;
        end else begin
            if (s1_load_c) s1_valid      <= bus.in_valid;
            if (s1_en_c)   s1_last       <= bus.in_last;
            if (s2_load_c) bus.out_valid <= s1_valid;
            if (s2_en_c) begin
                bus.out_last <= s1_last;
                bus.out_sat  <= sat_re_c | sat_im_c;
            end
        end
    end

    // A clear in the same cycle as a counted beat drops that beat's event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end else if (stat_clr) begin
            sat_count  <= '0;
            sat_sticky <= 1'b0;
        end else if (sat_hit_c) begin
            if (sat_count != '1) sat_count <= sat_count + CNT_W'(1);
            sat_sticky <= 1'b1;
        end
    end

endmodule
